fetch_buffer: RTL and testbench

Instruction prefetch stage between the instruction memory and the IF/ID pipeline register of the 5-stage RV32I core. Keeps up to DEPTH in-order fetch requests in flight to a variable-latency memory and queues the returned instructions with their PCs. It presents one instruction per cycle downstream under a valid/ready handshake. On a taken branch or jump redirect it flushes all queued and in-flight instructions and restarts fetch at the new PC.

---
 rtl/fetch_buffer_pkg.sv | 13 +
 rtl/fetch_buffer_if.sv | 30 +++
 rtl/fetch_buffer_sync_fifo.sv | 51 +++++
 rtl/fetch_buffer.sv | 90 +++++++++
 tb/tb_fetch_buffer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle of the instruction-memory bus, redirect input and downstream handshake.
interface fetch_buffer_if;

    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        i_ready;

    // Fetch-buffer side
    modport master (
        output o_imem_req, o_imem_addr, o_valid, o_pc, o_instr,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  i_redirect, i_redirect_pc, i_ready
    );

    // Memory / pipeline side
    modport slave (
        input  o_imem_req, o_imem_addr, o_valid, o_pc, o_instr,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output i_redirect, i_redirect_pc, i_ready
    );

endinterface

// File: rtl/fetch_buffer_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a combinational head.
// Push at full is accepted only together with a pop; clear empties it.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: keeps up to DEPTH in-order requests in flight,
// tags each response with its PC and queues it for the IF/ID register.
// A redirect flushes the queue and drops every response still in flight.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    fetch_buffer_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fpc;
    logic [31:0]   redirect_pc_w;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] q_count;
    logic [CW-1:0] discard;
    logic [CW:0]   credits;
    logic          resp;
    logic          accept;
    logic          q_push;
    logic          q_pop;
    logic          q_valid;
    logic [31:0]   tag_pc;
    fetch_entry_t  q_in;
    fetch_entry_t  q_head;

    // A slot is reserved in the queue for every in-flight request, so the
    // queue can never overflow when responses arrive.
    assign credits       = (CW+1)'(DEPTH) - (CW+1)'(q_count) - (CW+1)'(outstanding);
    assign resp          = bus.i_imem_rvalid && (outstanding != '0);
    assign bus.o_imem_req  = (credits != '0) && !bus.i_redirect;
    assign bus.o_imem_addr = fpc;
    assign accept        = bus.o_imem_req && bus.i_imem_ready;
    assign redirect_pc_w = bus.i_redirect_pc & ~32'h3;

    assign q_valid = (q_count != '0);
    assign q_push  = resp && (discard == '0) && !bus.i_redirect;
    assign q_pop   = q_valid && bus.i_ready && !bus.i_redirect;
    assign q_in    = '{pc: tag_pc, instr: bus.i_imem_rdata};

    assign bus.o_valid = q_valid;
    assign bus.o_pc    = q_valid ? q_head.pc    : 32'h0;
    assign bus.o_instr = q_valid ? q_head.instr : NOP_INSN;

    // Tag FIFO: its occupancy is exactly the number of outstanding requests
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (accept),
        .push_data (fpc),
        .pop       (resp),
        .clear     (1'b0),
        .count     (outstanding),
        .head      (tag_pc)
    );

    // Instruction queue feeding the IF/ID register
    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_insn_q (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .clear     (bus.i_redirect),
        .count     (q_count),
        .head      (q_head)
    );

    // Fetch PC and discard counter; redirect has priority over everything.
    // On redirect, outstanding already includes responses still owed to an
    // earlier discard, so the new discard is simply all remaining in-flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fpc     <= RESET_PC;
            discard <= '0;
        end else if (bus.i_redirect) begin
            fpc     <= redirect_pc_w;
            discard <= outstanding - CW'(resp);
        end else begin
            if (accept)                    fpc     <= fpc + 32'd4;
            if (resp && (discard != '0))   discard <= discard - 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: memory model with configurable latency,
// PC scoreboard for emitted instructions, table of redirect addresses.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        exp_req;
    } rrow_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int cyc, lat, n_pass, n_chk, inflight, n_acc, pops, first_pop_cyc, last_pop_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory response for the current cycle, in order, after the latency
    task automatic step_pre();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.i_imem_rvalid = 1'b1;
            bus.i_imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
            inflight--;
        end else begin
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_rdata  = 32'h0;
        end
        #1;
    endtask

    // Record accepted requests, score consumed instructions, advance a cycle
    task automatic step_post();
        logic [31:0] e;
        if (bus.o_imem_req && bus.i_imem_ready) begin
            mem_q.push_back('{addr: bus.o_imem_addr, due: cyc + lat});
            inflight++;
            n_acc++;
        end
        if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
            pops++;
            if (pops == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pop: got pc %h, want no output (cycle %0d)", bus.o_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", bus.o_pc, e);
                check("sb_instr", bus.o_instr, mem_word(e));
            end
        end
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        bus.i_ready = 1'b0;
        check_int({name, "_drained_left"}, exp_q.size(), 0);
    endtask

    task automatic redirect(input logic [31:0] pc, input logic [31:0] first, input int n);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
        step();
        bus.i_redirect = 1'b0;
    endtask

    // Asserts reset, checks reset outputs, releases at a falling edge
    task automatic do_reset();
        i_rst_n           = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        bus.i_ready       = 1'b0;
        bus.i_imem_ready  = 1'b1;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = 32'h0;
        mem_q.delete();
        exp_q.delete();
        inflight = 0;
        n_acc    = 0;
        pops     = 0;
        #1;
        check_int("rst_req", bus.o_imem_req, 1);
        check("rst_addr", bus.o_imem_addr, 32'h0);
        check_int("rst_valid", bus.o_valid, 0);
        check("rst_pc", bus.o_pc, 32'h0);
        check("rst_instr", bus.o_instr, NOP_INSN);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc     = 0;
    endtask

    // Memory must never answer with nothing outstanding
    always @(posedge i_clk) begin
        if (i_rst_n) assert (inflight >= 0) else $error("spurious imem response");
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rrow_t tbl[4];
        tbl[0] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100, exp_valid: 1'b0, exp_req: 1'b1};
        tbl[1] = '{rpc: 32'h0000_0202, exp_addr: 32'h0000_0200, exp_valid: 1'b0, exp_req: 1'b1};
        tbl[2] = '{rpc: 32'h8000_0001, exp_addr: 32'h8000_0000, exp_valid: 1'b0, exp_req: 1'b1};
        tbl[3] = '{rpc: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC, exp_valid: 1'b0, exp_req: 1'b1};
        n_pass = 0;
        n_chk  = 0;
        cyc    = 0;
        lat    = 1;
        @(negedge i_clk);

        // Streaming with 1-cycle memory
        do_reset();
        lat = 1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(4 * i));
        drain("stream", 40);
        check_int("stream_first_cycle", first_pop_cyc, 2);
        check_int("stream_last_cycle", last_pop_cyc, 17);

        // Latency 3 with downstream stalled: credits cap requests, head holds
        do_reset();
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            step_pre();
            if (bus.o_valid) begin
                check("hold_pc", bus.o_pc, 32'h0);
                check("hold_instr", bus.o_instr, mem_word(32'h0));
            end
            if (i == 9) check_int("stall_req_low", bus.o_imem_req, 0);
            step_post();
        end
        check_int("stall_accepts", n_acc, 4);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(4 * i));
        drain("stall_drain", 80);

        // Redirect with three responses in flight (reset lands mid-operation)
        do_reset();
        lat = 4;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_int("r1_inflight", inflight, 3);
        redirect(32'h100, 32'h100, 3);
        step_pre();
        check_int("r1_valid", bus.o_valid, 0);
        check("r1_addr", bus.o_imem_addr, 32'h100);
        check_int("r1_req", bus.o_imem_req, 1);
        step_post();
        drain("redir1", 60);

        // Second redirect while the first discard is still pending
        do_reset();
        lat = 4;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect(32'h100, 32'h100, 3);
        step();
        redirect(32'h200, 32'h200, 3);
        drain("redir2", 60);

        // Redirect coinciding with a response and a head handshake
        do_reset();
        lat = 1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 6; i++) step();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h300;
        step_pre();
        check_int("r3_pre_valid", bus.o_valid, 1);
        check_int("r3_pre_rvalid", bus.i_imem_rvalid, 1);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h300 + 32'(4 * i));
        step_post();
        bus.i_redirect = 1'b0;
        step_pre();
        check_int("r3_valid_r1", bus.o_valid, 0);
        check("r3_addr_r1", bus.o_imem_addr, 32'h300);
        step_post();
        step_pre();
        check_int("r3_valid_r2", bus.o_valid, 0);
        step_post();
        step_pre();
        check_int("r3_valid_r3", bus.o_valid, 1);
        check("r3_pc_r3", bus.o_pc, 32'h300);
        step_post();
        drain("redir3", 40);

        // Redirect address alignment table, then fetch PC wrap-around
        do_reset();
        lat = 1;
        bus.i_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            step();
            step();
            redirect(tbl[r].rpc, tbl[r].exp_addr, 0);
            step_pre();
            check("tbl_addr", bus.o_imem_addr, tbl[r].exp_addr);
            check_int("tbl_valid", bus.o_valid, tbl[r].exp_valid);
            check_int("tbl_req", bus.o_imem_req, tbl[r].exp_req);
            step_post();
        end
        exp_q.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        bus.i_ready = 1'b1;
        drain("wrap", 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
